// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter and its round-robin picker.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_e;

    // Bits needed to index n items; returns at least 1 so that n=1 still has a legal width.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: the first set request after rr_ptr wins, with wrap-around.
module uart_rr_picker
    import uart_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] rr_ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any_req
);

    logic [IW-1:0] cand;

    always_comb begin
        grant   = '0;
        idx     = '0;
        any_req = 1'b0;
        cand    = '0;
        // Scan rr_ptr+1 .. rr_ptr+N so the previous owner is considered last.
        for (int i = 1; i <= N; i++) begin
            cand = IW'((int'(rr_ptr) + i) % N);
            if (!any_req && req[cand]) begin
                any_req     = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin sharing of one uart_tx among NUM_REQ byte-stream requesters.
//   state     | meaning
//   IDLE      | no owner; grant the next requester once the UART is not busy
//   SEND      | owner holds the UART; launch its byte or count idle gap cycles
//   WAIT_BUSY | byte launched; wait for the UART to report busy
//   WAIT_DONE | byte in flight; on completion release or go back to SEND
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int MAX_PKT     = 16,
    parameter int GAP_TIMEOUT = 255
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [NUM_REQ-1:0]   REQ_VALID,
    input  logic [8*NUM_REQ-1:0] REQ_DATA,
    input  logic [NUM_REQ-1:0]   REQ_LAST,
    output logic [NUM_REQ-1:0]   REQ_ACK,
    output logic [NUM_REQ-1:0]   GRANT,
    output logic                 TX_START,
    output logic [7:0]           TX_DATA,
    input  logic                 TX_BUSY,
    output logic                 ARB_IDLE
);

    localparam int IW = clog2(NUM_REQ);

    arb_state_e           state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IW-1:0]        gidx_q, gidx_d;
    logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [7:0]           byte_cnt_q, byte_cnt_d;
    logic [15:0]          gap_cnt_q, gap_cnt_d;
    logic                 last_q, last_d;
    logic                 tx_start_q, tx_start_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic [NUM_REQ-1:0]   req_ack_q, req_ack_d;
    logic                 arb_idle_q, arb_idle_d;

    logic [NUM_REQ-1:0]   pick_grant;
    logic [IW-1:0]        pick_idx;
    logic                 pick_any;
    logic                 rel;

    uart_rr_picker #(.N(NUM_REQ), .IW(IW)) u_picker (
        .req     (REQ_VALID),
        .rr_ptr  (rr_ptr_q),
        .grant   (pick_grant),
        .idx     (pick_idx),
        .any_req (pick_any)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        gidx_d     = gidx_q;
        rr_ptr_d   = rr_ptr_q;
        byte_cnt_d = byte_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        last_d     = last_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        req_ack_d  = '0;
        rel        = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_any && !TX_BUSY) begin
                    grant_d    = pick_grant;
                    gidx_d     = pick_idx;
                    byte_cnt_d = '0;
                    gap_cnt_d  = '0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (REQ_VALID[gidx_q]) begin
                    if (!TX_BUSY) begin
                        tx_start_d = 1'b1;
                        tx_data_d  = REQ_DATA[{gidx_q, 3'b000} +: 8];
                        req_ack_d  = grant_q;
                        last_d     = REQ_LAST[gidx_q];
                        byte_cnt_d = byte_cnt_q + 8'd1;
                        gap_cnt_d  = '0;
                        state_d    = WAIT_BUSY;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 16'd1;
                    rel       = (gap_cnt_d == 16'(GAP_TIMEOUT));
                end
            end
            WAIT_BUSY: begin
                if (TX_BUSY) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!TX_BUSY) begin
                    if (last_q || byte_cnt_q == 8'(MAX_PKT)) rel = 1'b1;
                    else                                     state_d = SEND;
                end
            end
            default: state_d = IDLE;
        endcase

        // The releasing owner becomes lowest priority for the next pick.
        if (rel) begin
            grant_d  = '0;
            rr_ptr_d = gidx_q;
            state_d  = IDLE;
        end

        arb_idle_d = (state_d == IDLE);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            gidx_q     <= '0;
            rr_ptr_q   <= IW'(NUM_REQ - 1);
            byte_cnt_q <= '0;
            gap_cnt_q  <= '0;
            last_q     <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            req_ack_q  <= '0;
            arb_idle_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            gidx_q     <= gidx_d;
            rr_ptr_q   <= rr_ptr_d;
            byte_cnt_q <= byte_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            last_q     <= last_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            req_ack_q  <= req_ack_d;
            arb_idle_q <= arb_idle_d;
        end
    end

    assign GRANT    = grant_q;
    assign REQ_ACK  = req_ack_q;
    assign TX_START = tx_start_q;
    assign TX_DATA  = tx_data_q;
    assign ARB_IDLE = arb_idle_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester queues, a uart_tx busy model and a TX scoreboard.
module tb_uart_tx_arbiter;

    localparam int NR = 4;

    logic            CLK = 1'b0;
    logic            RST_N = 1'b0;
    logic [NR-1:0]   REQ_VALID = '0;
    logic [8*NR-1:0] REQ_DATA = '0;
    logic [NR-1:0]   REQ_LAST = '0;
    logic [NR-1:0]   REQ_ACK;
    logic [NR-1:0]   GRANT;
    logic            TX_START;
    logic [7:0]      TX_DATA;
    logic            TX_BUSY = 1'b0;
    logic            ARB_IDLE;

    uart_tx_arbiter #(.NUM_REQ(NR), .MAX_PKT(3), .GAP_TIMEOUT(8)) dut (
        .CLK(CLK), .RST_N(RST_N), .REQ_VALID(REQ_VALID), .REQ_DATA(REQ_DATA),
        .REQ_LAST(REQ_LAST), .REQ_ACK(REQ_ACK), .GRANT(GRANT), .TX_START(TX_START),
        .TX_DATA(TX_DATA), .TX_BUSY(TX_BUSY), .ARB_IDLE(ARB_IDLE)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [1:0] idx;
        logic [7:0] data;
    } sb_t;

    typedef struct packed {
        logic [3:0]  mask;   // requesters each holding one 1-byte LAST packet
        logic [2:0]  n;      // number of grants expected
        logic [15:0] ord;    // expected grant order, first in ord[3:0]
    } vec_t;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0, fall_cyc = 0, start_cyc = 0, tx_starts = 0;
    int   busy_len = 10, bcnt = 0;
    logic busy_hold = 1'b0, prev_busy;
    int   acks [NR];
    sb_t  sbq [$];
    sb_t  e;
    logic [8:0] rq [NR][$];
    vec_t vecs [7];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic bit all_empty();
        bit r;
        r = (sbq.size() == 0);
        for (int i = 0; i < NR; i++) if (rq[i].size() != 0) r = 1'b0;
        return r;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        while (!(all_empty() && GRANT == '0 && !TX_BUSY && ARB_IDLE) && k < 2000) begin
            tick();
            k++;
        end
        if (k >= 2000) begin
            miscompares++;
            $display("FAIL %s_timeout: arbiter did not drain (grant %0h, pending sb %0d)", nm, GRANT, sbq.size());
        end
        check({nm, "_grant_idle"}, 32'(GRANT), 0);
        check({nm, "_arb_idle"}, 32'(ARB_IDLE), 1);
        repeat (2) tick();
    endtask

    task automatic wait_starts(input int target, input string nm);
        int k;
        k = 0;
        while (tx_starts < target && k < 500) begin
            tick();
            k++;
        end
        if (k >= 500) begin
            miscompares++;
            $display("FAIL %s_start_timeout: tx_starts %0d, expected %0d", nm, tx_starts, target);
        end
    endtask

    // Requester model, uart_tx busy model and TX scoreboard, all acting 1 time unit after each edge.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            cyc++;
            if (TX_START) begin
                tx_starts++;
                start_cyc = cyc;
                bcnt = busy_len;
                if (sbq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL tx_unexpected: TX_START with data %0h, none expected", TX_DATA);
                end else begin
                    e = sbq.pop_front();
                    check("tx_data", 32'(TX_DATA), 32'(e.data));
                    check("tx_ack", 32'(REQ_ACK), 32'(1) << e.idx);
                    check("tx_grant", 32'(GRANT), 32'(1) << e.idx);
                end
            end else if (bcnt > 0) begin
                bcnt--;
            end
            for (int i = 0; i < NR; i++) begin
                if (REQ_ACK[i]) begin
                    acks[i]++;
                    if (rq[i].size() > 0) void'(rq[i].pop_front());
                end
            end
            prev_busy = TX_BUSY;
            TX_BUSY = busy_hold || (bcnt > 0);
            if (prev_busy && !TX_BUSY) fall_cyc = cyc;
            for (int i = 0; i < NR; i++) begin
                if (rq[i].size() > 0) begin
                    REQ_VALID[i]      = 1'b1;
                    REQ_DATA[8*i +: 8] = rq[i][0][7:0];
                    REQ_LAST[i]       = rq[i][0][8];
                end else begin
                    REQ_VALID[i]      = 1'b0;
                    REQ_DATA[8*i +: 8] = 8'h00;
                    REQ_LAST[i]       = 1'b0;
                end
            end
        end
    end

    initial begin
        int n0, a0;
        for (int i = 0; i < NR; i++) acks[i] = 0;
        vecs[0] = '{4'b0101, 3'd2, 16'h0020};
        vecs[1] = '{4'b0101, 3'd2, 16'h0020};
        vecs[2] = '{4'b0101, 3'd2, 16'h0020};
        vecs[3] = '{4'b1111, 3'd4, 16'h2103};
        vecs[4] = '{4'b1010, 3'd2, 16'h0013};
        vecs[5] = '{4'b0011, 3'd2, 16'h0010};
        vecs[6] = '{4'b1000, 3'd1, 16'h0003};

        repeat (3) tick();
        check("rst_grant", 32'(GRANT), 0);
        check("rst_ack", 32'(REQ_ACK), 0);
        check("rst_tx_start", 32'(TX_START), 0);
        check("rst_tx_data", 32'(TX_DATA), 0);
        check("rst_arb_idle", 32'(ARB_IDLE), 1);
        RST_N = 1'b1;
        repeat (2) tick();

        // Round-robin table: each vector loads 1-byte packets and expects a fixed grant order.
        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < NR; i++)
                if (vecs[v].mask[i]) rq[i].push_back({1'b1, 8'(v * 16 + i)});
            for (int k = 0; k < int'(vecs[v].n); k++) begin
                e.idx  = vecs[v].ord[4*k +: 2];
                e.data = 8'(v * 16 + int'(vecs[v].ord[4*k +: 4]));
                sbq.push_back(e);
            end
            wait_idle($sformatf("rr_vec%0d", v));
        end

        // MAX_PKT=3: requester 1 is cut after 3 bytes, requester 3 runs, then 1 resumes.
        for (int b = 0; b < 5; b++) rq[1].push_back({1'b0, 8'(8'h10 + b)});
        rq[3].push_back({1'b1, 8'h30});
        sbq.push_back('{2'd1, 8'h10}); sbq.push_back('{2'd1, 8'h11});
        sbq.push_back('{2'd1, 8'h12}); sbq.push_back('{2'd3, 8'h30});
        sbq.push_back('{2'd1, 8'h13}); sbq.push_back('{2'd1, 8'h14});
        wait_idle("max_pkt");

        // Single requester, two bytes, with grant and start latency checked.
        a0 = acks[0];
        rq[0].push_back({1'b0, 8'h55});
        rq[0].push_back({1'b1, 8'hA3});
        sbq.push_back('{2'd0, 8'h55}); sbq.push_back('{2'd0, 8'hA3});
        tick();
        tick();
        check("lat_grant", 32'(GRANT), 1);
        check("lat_no_start", 32'(TX_START), 0);
        tick();
        check("lat_start", 32'(TX_START), 1);
        check("lat_data", 32'(TX_DATA), 32'h55);
        wait_idle("single");
        check("single_acks", 32'(acks[0] - a0), 2);

        // Gap timeout: one byte without LAST, then VALID stays low.
        n0 = tx_starts;
        rq[0].push_back({1'b0, 8'h77});
        sbq.push_back('{2'd0, 8'h77});
        wait_starts(n0 + 1, "gap");
        begin
            int k;
            k = 0;
            while ((tx_starts == n0 + 1) && (TX_BUSY || cyc == start_cyc) && k < 100) begin tick(); k++; end
            k = 0;
            while (GRANT != '0 && k < 100) begin tick(); k++; end
        end
        check("gap_release_cycles", 32'(cyc - fall_cyc), 9);
        repeat (3) tick();
        check("gap_no_extra_start", 32'(tx_starts), 32'(n0 + 1));
        wait_idle("gap");

        // Reset while a byte is in flight; the UART stays busy past reset release.
        n0 = tx_starts;
        rq[0].push_back({1'b0, 8'h61});
        rq[0].push_back({1'b1, 8'h62});
        sbq.push_back('{2'd0, 8'h61}); sbq.push_back('{2'd0, 8'h62});
        wait_starts(n0 + 1, "rst_mid");
        repeat (3) tick();
        busy_hold = 1'b1;
        RST_N = 1'b0;
        #1;
        check("rstmid_grant", 32'(GRANT), 0);
        check("rstmid_tx_start", 32'(TX_START), 0);
        check("rstmid_tx_data", 32'(TX_DATA), 0);
        check("rstmid_arb_idle", 32'(ARB_IDLE), 1);
        repeat (2) tick();
        RST_N = 1'b1;
        rq[2].push_back({1'b1, 8'h63});
        sbq.push_back('{2'd2, 8'h63});
        for (int k = 0; k < 6; k++) begin
            tick();
            check("rstmid_hold_no_grant", 32'(GRANT), 0);
        end
        busy_hold = 1'b0;
        tick();
        check("rstmid_busy_falling_no_grant", 32'(GRANT), 0);
        tick();
        check("rstmid_first_grant", 32'(GRANT), 1);
        wait_idle("rst_mid");

        // Long busy: no second start or ack until busy falls, then start exactly 2 cycles later.
        busy_len = 20;
        n0 = tx_starts;
        rq[2].push_back({1'b0, 8'h81});
        rq[2].push_back({1'b1, 8'h82});
        sbq.push_back('{2'd2, 8'h81}); sbq.push_back('{2'd2, 8'h82});
        wait_starts(n0 + 1, "busy_hold");
        for (int k = 0; k < 19; k++) begin
            tick();
            check("busy_no_start", 32'(TX_START), 0);
            check("busy_no_ack", 32'(REQ_ACK), 0);
        end
        wait_starts(n0 + 2, "busy_hold2");
        check("busy_restart_latency", 32'(start_cyc - fall_cyc), 2);
        wait_idle("busy_hold");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
